// File: rtl/cameralink_uart_phy_if.sv
// -----------------------------------------------------------------------------
// cameralink_uart_phy_if
// Purpose : Byte-level handshake between the AXI-to-UART bridge and the
//           Camera Link serial PHY.
// Signals :
//   tx_start     bridge -> PHY  single-cycle send request
//   tx_data      bridge -> PHY  byte to send, valid with tx_start
//   tx_busy      PHY -> bridge  frame in flight on SerTC
//   rx_ready     PHY -> bridge  one-cycle pulse, rx_data holds a new byte
//   rx_data      PHY -> bridge  last good received byte
//   rx_frame_err PHY -> bridge  one-cycle pulse, stop bit sampled low
// Modports: master = bridge side, slave = PHY side.
// -----------------------------------------------------------------------------
interface cameralink_uart_phy_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_frame_err;

   modport master (
      output tx_start,
      output tx_data,
      input  tx_busy,
      input  rx_ready,
      input  rx_data,
      input  rx_frame_err
   );

   modport slave (
      input  tx_start,
      input  tx_data,
      output tx_busy,
      output rx_ready,
      output rx_data,
      output rx_frame_err
   );
endinterface

// File: rtl/cameralink_uart_phy.sv
// -----------------------------------------------------------------------------
// cameralink_uart_phy
// Purpose : Camera Link serial PHY (frame-grabber side). 8N1 UART, LSB first,
//           full duplex: SerTC is driven to the camera, SerTFG is received.
// Parameters:
//   CLK_FREQ_HZ  clock frequency of s_axi_aclk
//   BAUD_RATE    line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (>= 4)
// Ports:
//   s_axi_aclk    clock
//   s_axi_areset  synchronous active-high reset
//   bus           byte handshake (cameralink_uart_phy_if.slave)
//   loopback      (only with CL_UART_LOOPBACK_EN) 1 = RX listens to ser_tc
//   ser_tfg       serial line from camera, asynchronous
//   ser_tc        serial line to camera, idle high
// Build option: define CL_UART_LOOPBACK_EN to add the loopback port.
// -----------------------------------------------------------------------------
module cameralink_uart_phy #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 9600
) (
   input  logic                        s_axi_aclk,
   input  logic                        s_axi_areset,
   cameralink_uart_phy_if.slave        bus,
`ifdef CL_UART_LOOPBACK_EN
   input  logic                        loopback,
`endif
   input  logic                        ser_tfg,
   output logic                        ser_tc
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("cameralink_uart_phy: CLKS_PER_BIT must be at least 4");
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t        tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_idx_q;
   logic [7:0]       tx_shift_q;
   logic             ser_tc_q;
   logic             tx_busy_q;

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         ser_tc_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (bus.tx_start) begin
                  tx_shift_q <= bus.tx_data;
                  ser_tc_q   <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  tx_cnt_q   <= '0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_idx_q   <= '0;
                  ser_tc_q   <= tx_shift_q[0];
                  tx_state_q <= TX_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_idx_q == 3'd7) begin
                     ser_tc_q   <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     // Shift right so the next bit is always at [1] -> [0].
                     ser_tc_q   <= tx_shift_q[1];
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_idx_q   <= tx_idx_q + 3'd1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= TX_IDLE;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign ser_tc      = ser_tc_q;
   assign bus.tx_busy = tx_busy_q;

   // ---------------------------------------------------------------- RX
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   logic rx_line;
`ifdef CL_UART_LOOPBACK_EN
   assign rx_line = loopback ? ser_tc_q : ser_tfg;
`else
   assign rx_line = ser_tfg;
`endif

   logic             rx_sync1_q;
   logic             rx_sync2_q;
   logic             rx_prev_q;
   rx_state_t        rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_idx_q;
   logic [7:0]       rx_shift_q;
   logic [7:0]       rx_data_q;
   logic             rx_ready_q;
   logic             rx_err_q;
   logic             rx_fall;

   // Falling edge on the synchronised line marks a candidate start bit.
   assign rx_fall = rx_prev_q & ~rx_sync2_q;

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_ready_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_sync1_q <= rx_line;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
         rx_ready_q <= 1'b0;
         rx_err_q   <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               // Half-bit wait lands the sample point mid-bit for the
               // rest of the frame; a high line here means a glitch.
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q <= '0;
                  rx_idx_q <= '0;
                  rx_state_q <= rx_sync2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                  rx_idx_q   <= rx_idx_q + 3'd1;
                  if (rx_idx_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q <= '0;
                  if (rx_sync2_q) begin
                     rx_data_q  <= rx_shift_q;
                     rx_ready_q <= 1'b1;
                     rx_state_q <= RX_IDLE;
                  end else begin
                     rx_err_q   <= 1'b1;
                     rx_state_q <= RX_BREAK;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_BREAK: begin
               // Wait out a held-low line so it is not taken as a new start.
               if (rx_sync2_q) begin
                  rx_state_q <= RX_IDLE;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign bus.rx_data      = rx_data_q;
   assign bus.rx_ready     = rx_ready_q;
   assign bus.rx_frame_err = rx_err_q;

endmodule
